vx_mem_req_arb: RTL and testbench
=================================

Name: vx_mem_req_arb

Overview:
- Parametrised N-to-1 memory request arbiter with an elastic output buffer.
- Merges NUM_REQS request channels (valid/rw/byteen/addr/data/tag/ready) into one request stream toward the cache/memory side.
- Appends the winning channel index to the tag so responses can be routed back.
- Selectable round-robin or fixed-priority arbitration; a 2-entry output buffer cuts the ready path and sustains one request per cycle.

Parameters:
NUM_REQS, 4, number of input request channels (>=1)
DATA_WIDTH, 512, request data width in bits
ADDR_WIDTH, 26, request address width
TAG_IN_WIDTH, 8, per-channel input tag width
DATA_SIZE, DATA_WIDTH/8, byte-enable width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
LOG_NUM_REQS, (NUM_REQS>1) ? clog2(NUM_REQS) : 0, derived; index bits appended to tag
TAG_OUT_WIDTH, TAG_IN_WIDTH+LOG_NUM_REQS, derived output tag width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid_in  in  NUM_REQS  per-channel request valid
req_rw_in  in  NUM_REQS  per-channel 1=write, 0=read
req_byteen_in  in  NUM_REQS*DATA_SIZE  per-channel byte enables, channel i at slice i
req_addr_in  in  NUM_REQS*ADDR_WIDTH  per-channel address
req_data_in  in  NUM_REQS*DATA_WIDTH  per-channel write data
req_tag_in  in  NUM_REQS*TAG_IN_WIDTH  per-channel tag
req_ready_in  out  NUM_REQS  per-channel accept
req_valid_out  out  1  merged request valid
req_rw_out  out  1  merged rw
req_byteen_out  out  DATA_SIZE  merged byte enables
req_addr_out  out  ADDR_WIDTH  merged address
req_data_out  out  DATA_WIDTH  merged data
req_tag_out  out  TAG_OUT_WIDTH  {input tag, channel index}; index in LSBs
req_ready_out  in  1  downstream accept

Behaviour:
- One clock domain, clk. reset_n is asynchronous, active-low; all state is cleared on assertion, release is synchronous to clk.
- Reset values: buffer count 0, req_valid_out 0, req_ready_in all 0 while reset is asserted, rr pointer 0, buffer payload 0.
- Reset mid-operation: all buffered requests are discarded; no output appears after release until new input arrives.
- Grant (combinational from req_valid_in and the rr pointer only):
  - round-robin: first valid channel at or after the pointer, wrapping modulo NUM_REQS;
  - fixed priority: lowest valid index.
  - Exactly one or zero grant bits are set.
- req_ready_in[i] = grant[i] & (count != 2). There is no combinational path from req_ready_out to req_ready_in.
- Push: any grant while count != 2; the winner's payload enters the buffer tail with tag {tag_in[i], i[LOG_NUM_REQS-1:0]}.
- Pop: req_valid_out & req_ready_out.
- Count update: push only +1; pop only -1; push and pop together leave count unchanged (buffer rotates). Push is never allowed when count == 2, even with a same-cycle pop.
- req_valid_out = (count != 0); outputs show the head entry and stay stable while valid and not ready.
- Latency: 1 cycle from input handshake to req_valid_out. Sustained throughput is 1 request/cycle when req_ready_out is held high.
- Round-robin pointer update: only on a successful push, to (winner+1) mod NUM_REQS. Unchanged when stalled by full.
- Fixed-priority mode ignores the pointer.
- NUM_REQS == 1: no index bits, TAG_OUT_WIDTH = TAG_IN_WIDTH, and the tag passes unchanged. The buffer is still present.
- Payload of non-granted channels is ignored. Inputs are not required to hold valid; a dropped valid without a handshake is legal.

Decomposition:
- Shared package (vx_mem_pkg):
  - arbitration mode constants ARB_RR = 0, ARB_PRIO = 1;
  - clog2-based index-width helper;
  - packed request struct typedef {rw, byteen, addr, data, tag}, parameterised through width localparams.
- One natural sub-module: vx_elastic_buf2, a 2-entry valid/ready buffer with push/pop/count, reusable for response paths.
- The arbiter selection is kept in the top module.

Test Plan:
- Reset: hold reset_n=0 with all valid_in=1 -> req_valid_out=0, req_ready_in=0000. After release, first grant goes to channel 0.
- Round-robin fairness: NUM_REQS=4, all valid, ready_out=1, tags 0x10/0x21/0x32/0x43 -> output tags 0x40, 0x85, 0xCA, 0x10F in order 0,1,2,3,0…, one per cycle after 1-cycle latency.
- Backpressure: ready_out=0 for 5 cycles with ch2 valid -> exactly 2 pushes, then req_ready_in=0000. Outputs hold entry 1 stable. After ready_out=1, both drain in order with no loss or duplication.
- Fixed priority: ARB_MODE=1, ch1 and ch3 valid continuously -> only ch1 granted (index bits 01) while ch1 stays valid. Ch3 is granted the cycle after ch1 drops valid.
- Simultaneous push/pop at count=1: steady stream with ready_out=1 -> count stays 1, no bubbles over 100 requests, writes keep rw=1 and byteen=0xF…F intact.
- Mid-stream reset: assert reset_n=0 with count=2 -> req_valid_out falls asynchronously. After release, no stale entry is emitted and the pointer restarts at 0.

Source files
------------

// File: rtl/vx_mem_pkg.sv
// Purpose: shared types and helpers for the memory request path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: arbitration mode codes, index-width helper, default-width request struct.
package vx_mem_pkg;

  localparam int ARB_RR   = 0;
  localparam int ARB_PRIO = 1;

  localparam int MEM_DATA_WIDTH = 512;
  localparam int MEM_ADDR_WIDTH = 26;
  localparam int MEM_TAG_WIDTH  = 8;
  localparam int MEM_DATA_SIZE  = MEM_DATA_WIDTH / 8;

  // Bits needed to encode a channel index; a single channel needs none.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  typedef struct packed {
    logic                      rw;
    logic [MEM_DATA_SIZE-1:0]  byteen;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] data;
    logic [MEM_TAG_WIDTH-1:0]  tag;
  } mem_req_t;

endpackage

// File: rtl/vx_elastic_buf2.sv
// Purpose: 2-entry valid/ready elastic buffer (head/tail registers).
// Latency: 1 cycle from push to pop_vld.
// Backpressure: push_rdy depends only on occupancy (low when full), never on pop_rdy.
// Ports: push_vld/push_dat/push_rdy in, pop_vld/pop_dat/pop_rdy out, count = occupancy.
module vx_elastic_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  input  logic             pop_rdy,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign push_rdy = (count_q != 2'd2);
  assign pop_vld  = (count_q != 2'd0);
  assign pop_dat  = head_q;
  assign count    = count_q;

  assign push = push_vld & push_rdy;
  assign pop  = pop_vld & pop_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_dat;
          else                 tail_q <= push_dat;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Shifting the tail forward is harmless when it holds no live entry.
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Push requires not-full and pop requires not-empty, so count is 1:
          // the new entry replaces the departing head.
          head_q <= push_dat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vx_mem_req_arb.sv
// Purpose: N-to-1 memory request arbiter (round-robin or fixed priority) with 2-entry output buffer.
// Latency: 1 cycle from input handshake to req_valid_out; sustains 1 request/cycle.
// Backpressure: req_ready_in = grant & not-full; no combinational path from req_ready_out.
// Ports: req_*_in are NUM_REQS packed channels (channel i at slice i); req_*_out is the merged
//        stream, req_tag_out = {input tag, channel index} with the index in the LSBs.
module vx_mem_req_arb
  import vx_mem_pkg::*;
#(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH    = MEM_ADDR_WIDTH,
  parameter int TAG_IN_WIDTH  = MEM_TAG_WIDTH,
  parameter int DATA_SIZE     = DATA_WIDTH / 8,
  parameter int ARB_MODE      = ARB_RR,
  parameter int LOG_NUM_REQS  = idx_bits(NUM_REQS),
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS-1:0]              req_rw_in,
  input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQS-1:0]              req_ready_in,
  output logic                             req_valid_out,
  output logic                             req_rw_out,
  output logic [DATA_SIZE-1:0]             req_byteen_out,
  output logic [ADDR_WIDTH-1:0]            req_addr_out,
  output logic [DATA_WIDTH-1:0]            req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic                             req_ready_out
);

  // Pointer/index width is at least 1 so the single-channel build still elaborates.
  localparam int PTR_W = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;

  typedef struct packed {
    logic                     rw;
    logic [DATA_SIZE-1:0]     byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_t;

  logic [NUM_REQS-1:0]     grant;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W:0]          rr_sum;
  logic [PTR_W:0]          ptr_inc;
  logic [PTR_W-1:0]        ptr_nxt;
  logic [TAG_IN_WIDTH-1:0] sel_tag;
  logic [TAG_OUT_WIDTH-1:0] win_tag;
  req_t                    win_req;
  req_t                    head_req;
  logic                    buf_rdy;
  logic                    push_fire;
  logic [1:0]              buf_count;

  // Grant: depends only on req_valid_in and rr_ptr. Loops run from the
  // lowest-preference candidate down so the last hit (highest preference) wins.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    rr_sum  = '0;
    if (ARB_MODE == ARB_PRIO) begin
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (req_valid_in[i]) begin
          grant      = '0;
          grant[i]   = 1'b1;
          win_idx    = PTR_W'(i);
        end
      end
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        rr_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (int'(rr_sum) >= NUM_REQS) rr_sum = rr_sum - (PTR_W+1)'(NUM_REQS);
        if (req_valid_in[rr_sum[PTR_W-1:0]]) begin
          grant                    = '0;
          grant[rr_sum[PTR_W-1:0]] = 1'b1;
          win_idx                  = rr_sum[PTR_W-1:0];
        end
      end
    end
  end

  // Payload of the granted channel; non-granted channels are don't-care.
  always_comb begin
    win_req = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        win_req.rw     = req_rw_in[i];
        win_req.byteen = req_byteen_in[i*DATA_SIZE +: DATA_SIZE];
        win_req.addr   = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_req.data   = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tag        = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      end
    end
    win_req.tag = win_tag;
  end

  generate
    if (LOG_NUM_REQS > 0) begin : g_idx_tag
      assign win_tag = {sel_tag, win_idx};
    end else begin : g_plain_tag
      assign win_tag = sel_tag;
    end
  endgenerate

  // ready_in is forced low while reset is held, independent of occupancy.
  assign req_ready_in = grant & {NUM_REQS{buf_rdy & reset_n}};
  assign push_fire    = (|grant) & buf_rdy;

  // Next pointer is one past the winner, wrapping at NUM_REQS.
  always_comb begin
    ptr_inc = {1'b0, win_idx} + (PTR_W+1)'(1);
    ptr_nxt = (int'(ptr_inc) >= NUM_REQS) ? '0 : ptr_inc[PTR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (push_fire) begin
      rr_ptr <= ptr_nxt;
    end
  end

  vx_elastic_buf2 #(
    .WIDTH ($bits(req_t))
  ) u_obuf (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (|grant),
    .push_dat (win_req),
    .push_rdy (buf_rdy),
    .pop_vld  (req_valid_out),
    .pop_dat  (head_req),
    .pop_rdy  (req_ready_out),
    .count    (buf_count)
  );

  assign req_rw_out     = head_req.rw;
  assign req_byteen_out = head_req.byteen;
  assign req_addr_out   = head_req.addr;
  assign req_data_out   = head_req.data;
  assign req_tag_out    = head_req.tag;

  // Occupancy is observable inside the buffer; the top only needs buf_rdy.
  logic unused_count;
  assign unused_count = ^buf_count;

endmodule

// File: tb/tb_vx_mem_req_arb.sv
// Purpose: directed self-checking bench for vx_mem_req_arb (round-robin and fixed-priority builds).
// Latency: checks 1-cycle input-to-output latency and 1/cycle throughput.
// Backpressure: checks full-buffer stall, hold-stable outputs and in-order drain.
module tb_vx_mem_req_arb;

  localparam int N   = 4;
  localparam int DW  = 512;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int DS  = DW / 8;
  localparam int TOW = 10;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid_in;
  logic [N-1:0]    req_rw_in;
  logic [N*DS-1:0] req_byteen_in;
  logic [N*AW-1:0] req_addr_in;
  logic [N*DW-1:0] req_data_in;
  logic [N*TW-1:0] req_tag_in;
  logic            req_ready_out;

  logic [N-1:0]    rdy_in_rr;
  logic            vld_out_rr;
  logic            rw_out_rr;
  logic [DS-1:0]   be_out_rr;
  logic [AW-1:0]   addr_out_rr;
  logic [DW-1:0]   data_out_rr;
  logic [TOW-1:0]  tag_out_rr;

  logic [N-1:0]    rdy_in_p;
  logic            vld_out_p;
  logic            rw_out_p;
  logic [DS-1:0]   be_out_p;
  logic [AW-1:0]   addr_out_p;
  logic [DW-1:0]   data_out_p;
  logic [TOW-1:0]  tag_out_p;

  int passed;
  int total;

  logic [TW-1:0]  tag_v   [N];
  logic [TOW-1:0] exp_tag [N];

  vx_mem_req_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(rdy_in_rr),
    .req_valid_out(vld_out_rr), .req_rw_out(rw_out_rr), .req_byteen_out(be_out_rr),
    .req_addr_out(addr_out_rr), .req_data_out(data_out_rr), .req_tag_out(tag_out_rr),
    .req_ready_out(req_ready_out)
  );

  vx_mem_req_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .ARB_MODE(1)) dut_p (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(rdy_in_p),
    .req_valid_out(vld_out_p), .req_rw_out(rw_out_p), .req_byteen_out(be_out_p),
    .req_addr_out(addr_out_p), .req_data_out(data_out_p), .req_tag_out(tag_out_p),
    .req_ready_out(req_ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [DW-1:0] chan_data(input int i);
    return {16{32'hD000_0000 + 32'(i)}};
  endfunction

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
    req_addr_in[i*AW +: AW] = a;
    req_tag_in[i*TW +: TW]  = t;
    req_data_in[i*DW +: DW] = chan_data(i);
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    req_valid_in = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (vld_out_rr !== 1'b0) $display("FAIL rst_valid_out: got %b want 0", vld_out_rr);
    else passed++;
    total++;
    if (rdy_in_rr !== 4'b0000) $display("FAIL rst_ready_in_rr: got %b want 0000", rdy_in_rr);
    else passed++;
    total++;
    if (rdy_in_p !== 4'b0000) $display("FAIL rst_ready_in_prio: got %b want 0000", rdy_in_p);
    else passed++;
    total++;
    if (tag_out_rr !== 10'h000) $display("FAIL rst_payload: tag got %h want 000", tag_out_rr);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (rdy_in_rr !== 4'b0001) $display("FAIL rst_first_grant_rr: got %b want 0001", rdy_in_rr);
    else passed++;
    total++;
    if (rdy_in_p !== 4'b0001) $display("FAIL rst_first_grant_prio: got %b want 0001", rdy_in_p);
    else passed++;
  endtask

  task automatic test_rr_fair();
    logic [N-1:0] exp_rdy;
    logic [AW-1:0] exp_addr;
    req_ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      exp_addr = 26'h100 + 26'(k % 4);
      exp_rdy  = 4'b0001 << ((k + 1) % 4);
      total++;
      if (vld_out_rr !== 1'b1 || tag_out_rr !== exp_tag[k % 4])
        $display("FAIL rr_tag[%0d]: got vld=%b tag=%h want vld=1 tag=%h", k, vld_out_rr, tag_out_rr, exp_tag[k % 4]);
      else passed++;
      total++;
      if (addr_out_rr !== exp_addr || data_out_rr !== chan_data(k % 4))
        $display("FAIL rr_payload[%0d]: got addr=%h want addr=%h (data match=%b)", k, addr_out_rr, exp_addr, data_out_rr === chan_data(k % 4));
      else passed++;
      total++;
      if (rdy_in_rr !== exp_rdy) $display("FAIL rr_ready_in[%0d]: got %b want %b", k, rdy_in_rr, exp_rdy);
      else passed++;
    end
    req_valid_in = 4'h0;
    @(posedge clk);
    #1;
    total++;
    if (vld_out_rr !== 1'b0) $display("FAIL rr_drain: valid_out got %b want 0", vld_out_rr);
    else passed++;
  endtask

  task automatic test_backpressure();
    int pushes;
    pushes        = 0;
    req_ready_out = 1'b0;
    req_valid_in  = 4'b0100;
    set_ch(2, 26'h200, tag_v[2]);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rdy_in_rr[2] === 1'b1) pushes++;
      @(posedge clk);
      #1;
      if (pushes == 1) set_ch(2, 26'h201, tag_v[2]);
      total++;
      if (vld_out_rr !== 1'b1 || addr_out_rr !== 26'h200 || tag_out_rr !== 10'h0CA)
        $display("FAIL bp_hold[%0d]: got vld=%b addr=%h tag=%h want vld=1 addr=0000200 tag=0ca", c, vld_out_rr, addr_out_rr, tag_out_rr);
      else passed++;
    end
    #1;
    total++;
    if (pushes != 2) $display("FAIL bp_push_count: got %0d want 2", pushes);
    else passed++;
    total++;
    if (rdy_in_rr !== 4'b0000) $display("FAIL bp_full_ready: got %b want 0000", rdy_in_rr);
    else passed++;
    req_ready_out = 1'b1;
    req_valid_in  = 4'b0000;
    @(posedge clk);
    #1;
    total++;
    if (vld_out_rr !== 1'b1 || addr_out_rr !== 26'h201)
      $display("FAIL bp_drain_second: got vld=%b addr=%h want vld=1 addr=0000201", vld_out_rr, addr_out_rr);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (vld_out_rr !== 1'b0) $display("FAIL bp_drain_empty: valid_out got %b want 0", vld_out_rr);
    else passed++;
  endtask

  task automatic test_fixed_prio();
    req_ready_out = 1'b1;
    req_valid_in  = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (vld_out_p !== 1'b1 || tag_out_p !== 10'h085)
        $display("FAIL prio_ch1[%0d]: got vld=%b tag=%h want vld=1 tag=085", c, vld_out_p, tag_out_p);
      else passed++;
      total++;
      if (rdy_in_p !== 4'b0010) $display("FAIL prio_ready[%0d]: got %b want 0010", c, rdy_in_p);
      else passed++;
    end
    req_valid_in = 4'b1000;
    #1;
    total++;
    if (rdy_in_p !== 4'b1000) $display("FAIL prio_ch3_grant: got %b want 1000", rdy_in_p);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (vld_out_p !== 1'b1 || tag_out_p !== 10'h10F)
      $display("FAIL prio_ch3_out: got vld=%b tag=%h want vld=1 tag=10f", vld_out_p, tag_out_p);
    else passed++;
    req_valid_in = 4'b0000;
    @(posedge clk);
    #1;
    total++;
    if (vld_out_p !== 1'b0) $display("FAIL prio_drain: valid_out got %b want 0", vld_out_p);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    req_ready_out              = 1'b1;
    req_rw_in                  = 4'b0001;
    req_byteen_in[0 +: DS]     = '1;
    req_valid_in               = 4'b0001;
    for (int k = 0; k < 100; k++) begin
      a = 26'h1000 + 26'(k);
      set_ch(0, a, tag_v[0]);
      #1;
      total++;
      if (rdy_in_rr !== 4'b0001) $display("FAIL b2b_ready[%0d]: got %b want 0001", k, rdy_in_rr);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (vld_out_rr !== 1'b1 || rw_out_rr !== 1'b1 || be_out_rr !== {DS{1'b1}} || addr_out_rr !== a)
        $display("FAIL b2b_out[%0d]: got vld=%b rw=%b be_ones=%b addr=%h want vld=1 rw=1 be_ones=1 addr=%h",
                 k, vld_out_rr, rw_out_rr, be_out_rr === {DS{1'b1}}, addr_out_rr, a);
      else passed++;
    end
    req_valid_in = 4'b0000;
    req_rw_in    = 4'b0000;
    @(posedge clk);
    #1;
    total++;
    if (vld_out_rr !== 1'b0) $display("FAIL b2b_drain: valid_out got %b want 0", vld_out_rr);
    else passed++;
  endtask

  task automatic test_mid_reset();
    req_ready_out = 1'b0;
    req_valid_in  = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (vld_out_rr !== 1'b1 || rdy_in_rr !== 4'b0000)
      $display("FAIL mrst_full: got vld=%b ready_in=%b want vld=1 ready_in=0000", vld_out_rr, rdy_in_rr);
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (vld_out_rr !== 1'b0) $display("FAIL mrst_async_valid: got %b want 0", vld_out_rr);
    else passed++;
    repeat (2) @(posedge clk);
    req_valid_in = 4'b0000;
    @(negedge clk);
    reset_n       = 1'b1;
    req_ready_out = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (vld_out_rr !== 1'b0) $display("FAIL mrst_no_stale[%0d]: valid_out got %b want 0", c, vld_out_rr);
      else passed++;
    end
    req_valid_in = 4'hF;
    #1;
    total++;
    if (rdy_in_rr !== 4'b0001) $display("FAIL mrst_ptr_restart: ready_in got %b want 0001", rdy_in_rr);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (vld_out_rr !== 1'b1 || tag_out_rr !== 10'h040)
      $display("FAIL mrst_first_out: got vld=%b tag=%h want vld=1 tag=040", vld_out_rr, tag_out_rr);
    else passed++;
    req_valid_in = 4'h0;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    tag_v         = '{8'h10, 8'h21, 8'h32, 8'h43};
    exp_tag       = '{10'h040, 10'h085, 10'h0CA, 10'h10F};
    reset_n       = 1'b0;
    req_valid_in  = '0;
    req_rw_in     = '0;
    req_byteen_in = '0;
    req_addr_in   = '0;
    req_data_in   = '0;
    req_tag_in    = '0;
    req_ready_out = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 26'h100 + 26'(i), tag_v[i]);

    test_reset();
    test_rr_fair();
    test_backpressure();
    test_fixed_prio();
    test_back_to_back();
    test_mid_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
